// File: rtl/vga_capture.sv
// VGA receive path: recovers sync timing from an hs/vs/rgb stream, locks after two
// consistent frames and writes one pixel per unit cell. Define VGA_CAPTURE_ERRCNT_EN for err_cnt.
module vga_capture #(
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned V_TOTAL    = 525,
    parameter int unsigned H_ACT      = 143,
    parameter int unsigned V_ACT      = 35,
    parameter int unsigned ACT_W      = 640,
    parameter int unsigned ACT_H      = 480,
    parameter int unsigned UNIT_SHIFT = 3
) (
    input  logic                  vga_clk,
    input  logic                  clr,
    input  logic                  hs,
    input  logic                  vs,
    input  logic [3:0]            r,
    input  logic [3:0]            g,
    input  logic [3:0]            b,
    output logic                  wr_en,
    output logic [9-UNIT_SHIFT:0] wr_col,
    output logic [8-UNIT_SHIFT:0] wr_row,
    output logic [11:0]           wr_data,
`ifdef VGA_CAPTURE_ERRCNT_EN
    output logic [7:0]            err_cnt,
`endif
    output logic                  locked,
    output logic                  frame_done
);

    localparam logic [9:0] HTotM1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] VTotM1 = 10'(V_TOTAL - 1);
    localparam logic [9:0] HActLo = 10'(H_ACT);
    localparam logic [9:0] HActHi = 10'(H_ACT + ACT_W - 1);
    localparam logic [9:0] VActLo = 10'(V_ACT);
    localparam logic [9:0] VActHi = 10'(V_ACT + ACT_H - 1);
    localparam logic [9:0] PosMax = 10'd1023;

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    state_e      r_state, w_state_d;
    logic        r_hs_q, r_hs_prev, r_vs_q, r_vs_prev;
    logic [11:0] r_pix_q;
    logic [9:0]  r_h_pos, r_v_pos, w_h_pos_d, w_v_pos_d;
    logic        r_vs_pend, w_vs_pend_d, r_bad_line, w_bad_line_d;
    logic        r_locked, r_frame_done, r_wr_en;
    logic [9-UNIT_SHIFT:0] r_wr_col;
    logic [8-UNIT_SHIFT:0] r_wr_row;
    logic [11:0] r_wr_data;

    logic        w_hs_fall, w_vs_fall, w_line_ok, w_timeout, w_frame_ok;
    logic        w_active, w_cell_top_left, w_wr;
    logic [9:0]  w_col;
    logic [8:0]  w_row;

    assign w_hs_fall  = r_hs_prev & ~r_hs_q;
    assign w_vs_fall  = r_vs_prev & ~r_vs_q;
    assign w_line_ok  = (r_h_pos == HTotM1);
    assign w_timeout  = (r_h_pos == PosMax);
    // The line ending in the same cycle as vs_fall still belongs to the frame being judged.
    assign w_frame_ok = (r_v_pos == VTotM1) && !r_bad_line && !(w_hs_fall && !w_line_ok);

    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            r_hs_q    <= 1'b0;
            r_hs_prev <= 1'b0;
            r_vs_q    <= 1'b0;
            r_vs_prev <= 1'b0;
            r_pix_q   <= '0;
        end else begin
            r_hs_q    <= hs;
            r_hs_prev <= r_hs_q;
            r_vs_q    <= vs;
            r_vs_prev <= r_vs_q;
            r_pix_q   <= {b, g, r};
        end
    end

    always_comb begin
        w_h_pos_d    = r_h_pos;
        w_v_pos_d    = r_v_pos;
        w_vs_pend_d  = r_vs_pend;
        w_bad_line_d = r_bad_line;
        if (w_hs_fall) begin
            w_h_pos_d = '0;
        end else if (!w_timeout) begin
            w_h_pos_d = r_h_pos + 10'd1;
        end
        if (w_hs_fall) begin
            if (w_vs_fall || r_vs_pend) begin
                w_v_pos_d = '0;
            end else if (r_v_pos != PosMax) begin
                w_v_pos_d = r_v_pos + 10'd1;
            end
            w_vs_pend_d = 1'b0;
        end else if (w_vs_fall) begin
            w_vs_pend_d = 1'b1;
        end
        if (w_vs_fall) begin
            w_bad_line_d = 1'b0;
        end else if (w_hs_fall && !w_line_ok) begin
            w_bad_line_d = 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StSearch: begin
                if (w_vs_fall) w_state_d = StVerify;
            end
            StVerify: begin
                if (w_timeout) begin
                    w_state_d = StSearch;
                end else if (w_vs_fall && w_frame_ok) begin
                    w_state_d = StLocked;
                end
            end
            StLocked: begin
                if (w_timeout || (w_hs_fall && !w_line_ok) ||
                    (w_vs_fall && (r_v_pos != VTotM1))) begin
                    w_state_d = StSearch;
                end
            end
            default: w_state_d = StSearch;
        endcase
    end

    assign w_col           = r_h_pos - HActLo;
    assign w_row           = r_v_pos[8:0] - VActLo[8:0];
    assign w_active        = (r_h_pos >= HActLo) && (r_h_pos <= HActHi) &&
                             (r_v_pos >= VActLo) && (r_v_pos <= VActHi);
    assign w_cell_top_left = (w_col[UNIT_SHIFT-1:0] == '0) && (w_row[UNIT_SHIFT-1:0] == '0);
    // Gate on the next state so writes stop in the same cycle that locked falls.
    assign w_wr            = (w_state_d == StLocked) && w_active && w_cell_top_left;

    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            r_state      <= StSearch;
            r_h_pos      <= '0;
            r_v_pos      <= '0;
            r_vs_pend    <= 1'b0;
            r_bad_line   <= 1'b0;
            r_locked     <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_col     <= '0;
            r_wr_row     <= '0;
            r_wr_data    <= '0;
        end else begin
            r_state      <= w_state_d;
            r_h_pos      <= w_h_pos_d;
            r_v_pos      <= w_v_pos_d;
            r_vs_pend    <= w_vs_pend_d;
            r_bad_line   <= w_bad_line_d;
            r_locked     <= (w_state_d == StLocked);
            r_frame_done <= (r_state == StLocked) && w_vs_fall && (w_state_d == StLocked);
            r_wr_en      <= w_wr;
            if (w_wr) begin
                r_wr_col  <= w_col[9:UNIT_SHIFT];
                r_wr_row  <= w_row[8:UNIT_SHIFT];
                r_wr_data <= r_pix_q;
            end
        end
    end

`ifdef VGA_CAPTURE_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            r_err_cnt <= '0;
        end else if ((r_state == StLocked) && (w_state_d == StSearch) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign wr_en      = r_wr_en;
    assign wr_col     = r_wr_col;
    assign wr_row     = r_wr_row;
    assign wr_data    = r_wr_data;
    assign locked     = r_locked;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a shrunken 64x40 raster (32x24 active) to keep runs short.
module tb_vga_capture;

    localparam int HT  = 64;
    localparam int VT  = 40;
    localparam int HA  = 20;
    localparam int VA  = 6;
    localparam int AW  = 32;
    localparam int AH  = 24;
    localparam int HSW = 8;
    localparam int VSW = 2;
    localparam int US  = 3;
    localparam int CELLS = (AW >> US) * (AH >> US);

    logic          vga_clk = 1'b0;
    logic          clr = 1'b1;
    logic          hs = 1'b1, vs = 1'b1;
    logic [3:0]    r = '0, g = '0, b = '0;
    logic          wr_en, locked, frame_done;
    logic [9-US:0] wr_col;
    logic [8-US:0] wr_row;
    logic [11:0]   wr_data;
`ifdef VGA_CAPTURE_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif

    vga_capture #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT(HA), .V_ACT(VA),
        .ACT_W(AW), .ACT_H(AH), .UNIT_SHIFT(US)
    ) u_dut (
        .vga_clk    (vga_clk),
        .clr        (clr),
        .hs         (hs),
        .vs         (vs),
        .r          (r),
        .g          (g),
        .b          (b),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
`ifdef VGA_CAPTURE_ERRCNT_EN
        .err_cnt    (err_cnt),
`endif
        .locked     (locked),
        .frame_done (frame_done)
    );

    always #5 vga_clk = ~vga_clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int n_wr = 0, n_wr_unlocked = 0, n_bad_data = 0, n_fd = 0, n_nz = 0;
    int nz_col = 0, nz_row = 0, nz_data = 0, nz_cyc = 0;
    int t_lock = -1, t_unlock = -1, t_f0 = 0, t_mark = 0, t_pix = 0, t_stall = 0;
    int mark_vc = -1;
    logic prev_locked = 1'b0;
    int pix_mode = 0;  // 0: constant fill, 1: single pixel
    logic [11:0] const_pix = 12'hA5C;
    int sp_col = 0, sp_row = 0;
    logic [11:0] sp_val = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
        cyc++;
        if (wr_en === 1'b1) begin
            n_wr++;
            if (locked !== 1'b1) n_wr_unlocked++;
            if (pix_mode == 0 && wr_data !== const_pix) n_bad_data++;
            if (wr_data != 12'h000) begin
                n_nz++;
                nz_col  = 32'(wr_col);
                nz_row  = 32'(wr_row);
                nz_data = 32'(wr_data);
                nz_cyc  = cyc;
            end
        end
        if (frame_done === 1'b1) n_fd++;
        if (locked === 1'b1 && !prev_locked) t_lock = cyc;
        if (locked !== 1'b1 && prev_locked) t_unlock = cyc;
        prev_locked = (locked === 1'b1);
    endtask

    function automatic logic [11:0] pix_at(input int hc, input int vc);
        int col, row;
        if (hc < HA + 1 || hc > HA + AW || vc < VA || vc > VA + AH - 1) return 12'h000;
        col = hc - HA - 1;
        row = vc - VA;
        if (pix_mode == 0) return const_pix;
        return (col == sp_col && row == sp_row) ? sp_val : 12'h000;
    endfunction

    task automatic drive_raw(input logic h, input logic v, input logic [11:0] p);
        step();
        hs = h;
        vs = v;
        r  = p[3:0];
        g  = p[7:4];
        b  = p[11:8];
    endtask

    task automatic gen(input int hc, input int vc);
        logic [11:0] p;
        p = pix_at(hc, vc);
        drive_raw(hc >= HSW, vc >= VSW, p);
        if (hc == 0 && vc == 0) t_f0 = cyc;
        if (hc == 0 && vc == mark_vc) t_mark = cyc;
        if (pix_mode == 1 && p != 12'h000) t_pix = cyc;
    endtask

    task automatic run_line(input int vc, input int len);
        for (int hc = 0; hc < len; hc++) gen(hc, vc);
    endtask

    task automatic run_frame(input int nlines, input int bad_vc);
        for (int vc = 0; vc < nlines; vc++) run_line(vc, (vc == bad_vc) ? HT - 1 : HT);
    endtask

    task automatic single_pixel_frame(input int c, input int rw, input logic [11:0] v);
        pix_mode = 1;
        sp_col   = c;
        sp_row   = rw;
        sp_val   = v;
        n_nz     = 0;
        run_frame(VT, -1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) step();
        check_eq("rst_wr_en", 32'(wr_en), 0);
        check_eq("rst_wr_col", 32'(wr_col), 0);
        check_eq("rst_wr_row", 32'(wr_row), 0);
        check_eq("rst_wr_data", 32'(wr_data), 0);
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_frame_done", 32'(frame_done), 0);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) drive_raw(1'b1, 1'b1, 12'h000);

        // Constant fill: lock on the second vs_fall, then count cells per frame.
        run_frame(VT, -1);
        check_eq("no_lock_after_1_vs", 32'(locked), 0);
        n_wr = 0;
        n_fd = 0;
        run_frame(VT, -1);
        check_eq("lock_latency", 32'(t_lock - t_f0), 2);
        run_frame(VT, -1);
        check_eq("writes_2_frames", 32'(n_wr), 32'(2 * CELLS));
        check_eq("bad_data", 32'(n_bad_data), 0);
        check_eq("frame_done_cnt", 32'(n_fd), 1);

        // Single-pixel placement and latency.
        single_pixel_frame(8, 16, 12'h123);
        check_eq("px_nz_cnt", 32'(n_nz), 1);
        check_eq("px_col", 32'(nz_col), 1);
        check_eq("px_row", 32'(nz_row), 2);
        check_eq("px_data", 32'(nz_data), 32'h123);
        check_eq("px_latency", 32'(nz_cyc - t_pix), 2);
        single_pixel_frame(24, 16, 12'hFED);
        check_eq("px_last_cnt", 32'(n_nz), 1);
        check_eq("hold_col", 32'(wr_col), 3);
        check_eq("hold_row", 32'(wr_row), 2);
        check_eq("hold_data", 32'(wr_data), 32'hFED);
        single_pixel_frame(25, 17, 12'h777);
        check_eq("px_off_cell", 32'(n_nz), 0);

        // One short line while locked.
        pix_mode = 0;
        mark_vc  = 3;
        n_wr     = 0;
        run_frame(VT, 2);
        mark_vc  = -1;
        check_eq("short_line_unlock", 32'(t_unlock - t_mark), 2);
`ifdef VGA_CAPTURE_ERRCNT_EN
        check_eq("err_cnt_1", 32'(err_cnt), 1);
`endif
        run_frame(VT, -1);
        check_eq("no_wr_after_loss", 32'(n_wr), 0);

        // Relock, then stall hs high long enough for the h_pos timeout.
        for (int vc = 0; vc < 10; vc++) run_line(vc, HT);
        check_eq("relock_latency", 32'(t_lock - t_f0), 2);
        n_wr = 0;
        for (int i = 0; i < 1100; i++) begin
            drive_raw(1'b1, 1'b1, 12'hFFF);
            if (i == 0) t_stall = cyc;
        end
        // h_pos hits 1023 (HT-2) + 961 cycles into the stall; locked drops on the next sample.
        check_eq("stall_unlock", 32'(t_unlock - t_stall), 962);
        check_eq("stall_no_wr", 32'(n_wr), 0);
`ifdef VGA_CAPTURE_ERRCNT_EN
        check_eq("err_cnt_2", 32'(err_cnt), 2);
`endif

        // Short frame in VERIFY holds off lock; the following good frame locks.
        run_frame(VT - 1, -1);
        run_frame(VT, -1);
        check_eq("short_frame_no_lock", 32'(locked), 0);
        run_frame(VT, -1);
        check_eq("verify_relock", 32'(t_lock - t_f0), 2);

        // clr mid-frame.
        for (int vc = 0; vc < 12; vc++) run_line(vc, HT);
        for (int hc = 0; hc <= 30; hc++) gen(hc, 12);
        check_eq("pre_clr_data", 32'(wr_data), 32'hA5C);
        clr = 1'b1;
        #1;
        check_eq("clr_wr_en", 32'(wr_en), 0);
        check_eq("clr_wr_col", 32'(wr_col), 0);
        check_eq("clr_wr_row", 32'(wr_row), 0);
        check_eq("clr_wr_data", 32'(wr_data), 0);
        check_eq("clr_locked", 32'(locked), 0);
        check_eq("clr_frame_done", 32'(frame_done), 0);
`ifdef VGA_CAPTURE_ERRCNT_EN
        check_eq("clr_err_cnt", 32'(err_cnt), 0);
`endif
        gen(31, 12);
        gen(32, 12);
        check_eq("clr_hold_locked", 32'(locked), 0);
        clr  = 1'b0;
        n_wr = 0;
        for (int hc = 33; hc < HT; hc++) gen(hc, 12);
        for (int vc = 13; vc < VT; vc++) run_line(vc, HT);
        run_frame(VT, -1);
        check_eq("post_clr_no_wr", 32'(n_wr), 0);
        check_eq("post_clr_unlocked", 32'(locked), 0);
        run_frame(VT, -1);
        check_eq("post_clr_relock", 32'(t_lock - t_f0), 2);
        check_eq("post_clr_writes", 32'(n_wr), 32'(CELLS));
        check_eq("wr_while_unlocked", 32'(n_wr_unlocked), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA scan generator: samples an incoming hs/vs/r/g/b stream in the 800x525, 640x480 timing and recovers pixel coordinates.
- Runs a sync-lock state machine.
- Writes downsampled pixels into a unit-cell pixel RAM using the same {b,g,r} 12-bit packing the scan generator reads.
- Used for loopback self-test and for capturing an external VGA source into the frame buffer.

Parameters:
- H_TOTAL, 800, pixel clocks per line.
- V_TOTAL, 525, lines per frame.
- H_ACT, 143, h_pos of active column 0.
- V_ACT, 35, v_pos of active row 0.
- UNIT_SHIFT, 3, log2 of pixel-cell size; one RAM word per 2^UNIT_SHIFT x 2^UNIT_SHIFT block.

Ports:
- vga_clk  in  1  pixel clock
- clr  in  1  reset
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- r  in  4  red
- g  in  4  green
- b  in  4  blue
- wr_en  out  1  pixel RAM write strobe, one cycle
- wr_col  out  10-UNIT_SHIFT  RAM column address (col >> UNIT_SHIFT)
- wr_row  out  9-UNIT_SHIFT  RAM row address (row >> UNIT_SHIFT)
- wr_data  out  12  {b,g,r}: [3:0]=r, [7:4]=g, [11:8]=b
- locked  out  1  high while in LOCKED
- frame_done  out  1  one-cycle pulse at end of each captured frame

Behaviour:
- Reset clr is asynchronous and active-high; the clock is vga_clk. clr resets all state.
- Reset values: wr_en=0, wr_col=0, wr_row=0, wr_data=0, locked=0, frame_done=0. FSM=SEARCH, h_pos=0, v_pos=0.
- Input stage: hs, vs, r, g, b are registered once (hs_q, vs_q, pix_q). A second register holds the previous hs_q/vs_q for edge detection.
  - hs_fall = previous hs_q=1 and hs_q=0; vs_fall is defined the same way.
- h_pos (10 bit):
  - Cleared to 0 on the cycle hs_fall is seen, else +1.
  - Saturates at 1023; that is a timeout condition.
- v_pos (10 bit):
  - On hs_fall: cleared to 0 if vs_fall is in the same cycle or vs_q fell since the previous hs_fall; otherwise +1.
  - Saturates at 1023.
- line_ok: at hs_fall, h_pos == H_TOTAL-1.
- frame_ok: at vs_fall, v_pos == V_TOTAL-1, and no line_ok failure since the previous vs_fall. Track this with a sticky bad_line flag, cleared at vs_fall.
- FSM:
  - SEARCH -> VERIFY on first vs_fall.
  - VERIFY -> LOCKED on next vs_fall with frame_ok. If frame_ok is false, stay in VERIFY and restart the check.
  - LOCKED -> SEARCH on any line_ok failure at hs_fall, vs_fall with v_pos != V_TOTAL-1, or h_pos reaching 1023.
  - VERIFY -> SEARCH on h_pos reaching 1023.
- locked = (state == LOCKED). It is registered and changes the cycle after the transition condition.
- Active window: col = h_pos - H_ACT and row = v_pos - V_ACT, 10-bit wrap arithmetic. Active when:
  - H_ACT <= h_pos <= H_ACT+639, and
  - V_ACT <= v_pos <= V_ACT+479.
- Write rule: wr_en=1 for one cycle when LOCKED, the position is active, col[UNIT_SHIFT-1:0]==0 and row[UNIT_SHIFT-1:0]==0. This captures the top-left sample of each cell.
  - wr_col = col[9:UNIT_SHIFT], wr_row = row[8:UNIT_SHIFT], wr_data = {pix_q.b, pix_q.g, pix_q.r}.
  - wr_col, wr_row and wr_data hold their values when wr_en=0.
- Latency: pixel present on r/g/b at cycle t gives wr_* valid at t+2.
- frame_done: one-cycle pulse, registered, on the vs_fall that ends a frame while LOCKED and still LOCKED after evaluation.
- Lock loss mid-frame: wr_en drops the same cycle locked drops. No partial-line writes after the failure.
- clr mid-frame: outputs go to reset values immediately. Re-lock requires two full vs_fall edges after clr release.

Optional Feature:
- Macro VGA_CAPTURE_ERRCNT_EN.
- Defined: adds output port err_cnt [7:0], reset 0.
  - Increments by 1 on every LOCKED->SEARCH transition.
  - Saturates at 255. Cleared only by clr.
- Undefined: port absent, no counter logic. All other behaviour is identical.

Test Plan:
- Loopback from the scan generator, UNIT_SHIFT=3, constant din=12'hA5C:
  - locked=1 after exactly 2 vs_fall edges.
  - 80x60=4800 wr_en pulses per frame, all wr_data=12'hA5C.
  - One frame_done per frame.
- Pixel-position check: source drives pixel (col 8, row 16)=12'h123, all others 0 -> single nonzero write at wr_col=1, wr_row=2, wr_data=12'h123, 2 cycles after the input pixel.
- Inject one 799-clock line while LOCKED:
  - locked falls the cycle after that hs_fall; wr_en stays 0 until re-lock.
  - err_cnt=1 when VGA_CAPTURE_ERRCNT_EN is defined.
- Hold hs high for 1100 clocks while LOCKED -> timeout to SEARCH at h_pos=1023; no writes during the stall.
- Frame of 524 lines in VERIFY -> stays in VERIFY (locked=0). Next correct 525-line frame -> locked=1.
- Assert clr for 3 cycles mid-frame -> all outputs 0 during clr; after release, 0 writes until 2 vs_fall edges are seen.
